// File: rtl/pmem_pkg.sv
// rtl/pmem_pkg.sv - shared constants and FSM state type for the pmem line adapter
package pmem_pkg;
  localparam int LINE_W    = 256;
  localparam int BEAT_W    = 64;
  localparam int NUM_BEATS = LINE_W / BEAT_W;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;
endpackage

// File: rtl/pmem_line_buffer.sv
// rtl/pmem_line_buffer.sv - line register with whole-line load, beat write and beat read select
module pmem_line_buffer #(
  parameter  int LINE_W = 256,
  parameter  int BEAT_W = 64,
  localparam int BEATS  = LINE_W / BEAT_W,
  localparam int IDX_W  = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LINE_W-1:0] load_data,
  input  logic              beat_we,
  input  logic [IDX_W-1:0]  beat_idx,
  input  logic [BEAT_W-1:0] beat_wdata,
  output logic [LINE_W-1:0] line,
  output logic [BEAT_W-1:0] beat
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line <= '0;
    end else if (load) begin
      line <= load_data;
    end else if (beat_we) begin
      line[BEAT_W*beat_idx +: BEAT_W] <= beat_wdata;
    end
  end

  assign beat = line[BEAT_W*beat_idx +: BEAT_W];

endmodule

// File: rtl/pmem_line_adapter.sv
// rtl/pmem_line_adapter.sv - converts cache line requests into 4-beat memory bursts
module pmem_line_adapter #(
  parameter int LINE_W = pmem_pkg::LINE_W,
  parameter int BEAT_W = pmem_pkg::BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pmem_address,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic [31:0]       burst_address,
  output logic              burst_read,
  output logic              burst_write,
  output logic [BEAT_W-1:0] burst_wdata,
  input  logic [BEAT_W-1:0] burst_rdata,
  input  logic              burst_resp
);
  import pmem_pkg::*;

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wline_load;
  logic             rbeat_we;
  logic [BEAT_W-1:0] rbuf_beat;
  logic [LINE_W-1:0] wline;
  logic             unused;

  assign wline_load = (state == IDLE) && pmem_write;
  assign rbeat_we   = (state == READ) && burst_resp;

  // Read assembly and write data live in separate buffers so a write never disturbs pmem_rdata.
  pmem_line_buffer #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) u_rbuf (
    .clk(clk), .rst(rst), .load(1'b0), .load_data('0),
    .beat_we(rbeat_we), .beat_idx(cnt), .beat_wdata(burst_rdata),
    .line(pmem_rdata), .beat(rbuf_beat)
  );

  pmem_line_buffer #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) u_wbuf (
    .clk(clk), .rst(rst), .load(wline_load), .load_data(pmem_wdata),
    .beat_we(1'b0), .beat_idx(cnt), .beat_wdata('0),
    .line(wline), .beat(burst_wdata)
  );

  assign unused = ^{rbuf_beat, wline, pmem_address[OFF_W-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      pmem_resp     <= 1'b0;
      burst_read    <= 1'b0;
      burst_write   <= 1'b0;
      burst_address <= '0;
    end else begin
      pmem_resp <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pmem_write) begin
            burst_address <= {pmem_address[31:OFF_W], OFF_W'(0)};
            cnt           <= '0;
            burst_write   <= 1'b1;
            state         <= WRITE;
          end else if (pmem_read) begin
            burst_address <= {pmem_address[31:OFF_W], OFF_W'(0)};
            cnt           <= '0;
            burst_read    <= 1'b1;
            state         <= READ;
          end
        end
        READ, WRITE: begin
          if (burst_resp) begin
            // cnt stays at LAST through DONE; it only restarts when IDLE accepts a new request.
            if (cnt == LAST) begin
              burst_read  <= 1'b0;
              burst_write <= 1'b0;
              pmem_resp   <= 1'b1;
              state       <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pmem_line_adapter.md
PMEM_LINE_ADAPTER -- requirements
Module: pmem_line_adapter

Interface
REQ-001 The block SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-002 The block SHALL have parameter BEAT_W, default 64, burst beat width in bits; NUM_BEATS = LINE_W/BEAT_W = 4.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 pmem_address  input  32  line address from cache; bits [4:0] ignored.
REQ-007 pmem_read  input  1  line read request, held until pmem_resp.
REQ-008 pmem_write  input  1  line write request, held until pmem_resp.
REQ-009 pmem_wdata  input  256  line to write.
REQ-010 pmem_rdata  output  256  assembled read line.
REQ-011 pmem_resp  output  1  one-cycle completion pulse to cache.
REQ-012 burst_address  output  32  line-aligned burst address ({addr[31:5],5'b0}).
REQ-013 burst_read  output  1  burst read request, held until the final beat.
REQ-014 burst_write  output  1  burst write request, held until the final beat.
REQ-015 burst_wdata  output  64  current write beat.
REQ-016 burst_rdata  input  64  current read beat.
REQ-017 burst_resp  input  1  beat accepted/valid this cycle.

Function
REQ-018 The FSM SHALL have states IDLE, READ, WRITE, DONE.
REQ-019 IDLE: on pmem_read, latch aligned address, clear beat counter, go READ; on pmem_write, latch address and pmem_wdata, go WRITE.
REQ-020 Simultaneous pmem_read and pmem_write in IDLE SHALL be treated as a write.
REQ-021 READ: burst_read=1; each cycle with burst_resp=1 SHALL store burst_rdata into pmem_rdata[64*cnt +: 64] and increment cnt.
REQ-022 WRITE: burst_write=1, burst_wdata = latched line[64*cnt +: 64]; each burst_resp=1 cycle SHALL advance cnt.
REQ-023 On the burst_resp cycle with cnt==3, the FSM SHALL go DONE; burst_read/burst_write SHALL be 0 in DONE.
REQ-024 DONE: pmem_resp=1 for exactly one cycle, pmem_rdata stable and complete; next state IDLE unconditionally.
REQ-025 A request still high in the IDLE cycle immediately after DONE SHALL start a new transaction (cache responsibility to deassert).
REQ-026 burst_resp in IDLE or DONE SHALL be ignored; cnt SHALL wrap 3->0 only via IDLE re-entry.
REQ-027 Changes to pmem_address/pmem_wdata after acceptance SHALL NOT affect the transaction in flight.
REQ-028 Latency with zero-wait memory: request seen at edge N -> burst_read at N+1 -> beats N+1..N+4 -> pmem_resp at N+5.
REQ-029 pmem_rdata SHALL hold its last value until overwritten by the next read's beats.

Reset
REQ-030 On rst low, asynchronously: state IDLE, cnt 0, pmem_resp 0, burst_read 0, burst_write 0, burst_address 0, burst_wdata 0, pmem_rdata 0, latched line 0.
REQ-031 Reset mid-burst SHALL abort the transaction with no pmem_resp; the memory side is reset concurrently.

Structure
REQ-032 A shared package pmem_pkg SHALL hold the state enum type, LINE_W, BEAT_W, NUM_BEATS constants.
REQ-033 One sub-module pmem_line_buffer SHALL hold the 256-bit line register with beat-indexed write and beat-indexed read select; FSM and counter stay in the top.

Verification
REQ-034 Read, zero-wait: pmem_read, addr 0x0000_1234 -> burst_address 0x0000_1220, beats 0x11..,0x22..,0x33..,0x44.. -> pmem_rdata {0x44..,0x33..,0x22..,0x11..}, pmem_resp at N+5 for 1 cycle.
REQ-035 Write: pmem_wdata = 256'h{D,C,B,A} 64-bit words -> burst_wdata A,B,C,D in order on burst_resp cycles, then pmem_resp.
REQ-036 Wait states: burst_resp low 3 cycles between each beat -> beat order preserved, burst_read held, pmem_resp only after 4th beat.
REQ-037 Read and write both high -> write burst issued, burst_read never asserted.
REQ-038 rst low after 2 read beats -> outputs zero immediately, no pmem_resp; new read after release completes normally.
REQ-039 pmem_address changed mid-burst -> burst_address unchanged until DONE.
